// File: rtl/ysyx_22040759_pkg.sv
// Shared definitions for the memory stage: FSM states, load/store func3 codes, NOP encoding.
package ysyx_22040759_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } ms_state_e;

    // func3 codes for loads/stores; bits [1:0] give the access size
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // True when the low address bits are not a multiple of the access size
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        logic res;
        case (size)
            2'd0:    res = 1'b0;
            2'd1:    res = off[0];
            2'd2:    res = |off[1:0];
            default: res = |off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22040759_lsu_align.sv
// Lane alignment: store data/strobe placement and load data extraction with sign/zero extension.
module ysyx_22040759_lsu_align
    import ysyx_22040759_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]                func3_i,
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [XLEN-1:0]           st_data_i,
    input  logic [XLEN-1:0]           ld_raw_i,
    output logic [XLEN-1:0]           wdata_o,
    output logic [XLEN/8-1:0]         wstrb_o,
    output logic [XLEN-1:0]           ld_data_o
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [OFFW+2:0] shamt;
    logic [XLEN-1:0] st_mask;
    logic [NB-1:0]   strb_base;
    logic [XLEN-1:0] ld_sh;

    assign shamt = {off_i, 3'b000};

    // Store: mask data to access size, then shift data and strobe into the addressed lane
    always_comb begin
        st_mask   = '1;
        strb_base = '1;
        case (func3_i[1:0])
            2'b00: begin
                st_mask   = XLEN'(8'hFF);
                strb_base = NB'(1'b1);
            end
            2'b01: begin
                st_mask   = XLEN'(16'hFFFF);
                strb_base = NB'(2'b11);
            end
            2'b10: begin
                st_mask   = XLEN'(32'hFFFF_FFFF);
                strb_base = NB'(4'hF);
            end
            default: begin
                st_mask   = '1;
                strb_base = '1;
            end
        endcase
        wdata_o = (st_data_i & st_mask) << shamt;
        wstrb_o = strb_base << off_i;
    end

    // Load: bring the addressed bytes down to bit 0, then extend per func3
    always_comb begin
        ld_sh = ld_raw_i >> shamt;
        case (func3_i)
            F3_B:    ld_data_o = XLEN'($signed(ld_sh[7:0]));
            F3_H:    ld_data_o = XLEN'($signed(ld_sh[15:0]));
            F3_W:    ld_data_o = XLEN'($signed(ld_sh[31:0]));
            F3_BU:   ld_data_o = XLEN'(ld_sh[7:0]);
            F3_HU:   ld_data_o = XLEN'(ld_sh[15:0]);
            F3_WU:   ld_data_o = XLEN'(ld_sh[31:0]);
            F3_D:    ld_data_o = ld_sh;
            default: ld_data_o = ld_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// Memory pipeline stage: latches the EX result, issues at most one data-bus access per
// instruction, and hands the aligned result to WB.
// Optional: define YSYX_22040759_MISALIGN_CHK_EN to flag size-misaligned accesses on ms_misalign.
module ysyx_22040759_mem_stage
    import ysyx_22040759_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [XLEN-1:0]   es_pc,
    input  logic [XLEN-1:0]   es_alu_result,
    input  logic [XLEN-1:0]   es_src2,
    input  logic [31:0]       es_inst,
    input  logic [2:0]        es_func3,
    input  logic              es_mem_ren,
    input  logic              es_mem_wen,
    input  logic              es_reg_wen,
    input  logic [4:0]        es_rd,
    input  logic [1:0]        es_wreg_sel,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [XLEN-1:0]   ms_pc,
    output logic [XLEN-1:0]   ms_alu_result,
    output logic [XLEN-1:0]   ms_rdata,
    output logic [31:0]       ms_inst,
    output logic              ms_reg_wen,
    output logic [4:0]        ms_rd,
    output logic [1:0]        ms_wreg_sel,
`ifdef YSYX_22040759_MISALIGN_CHK_EN
    output logic              ms_misalign,
`endif
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

    ms_state_e         state_q, state_d;
    logic              ms_valid_q, ms_valid_d;
    logic [XLEN-1:0]   pc_q, alu_q, src2_q, rdata_q;
    logic [31:0]       inst_q;
    logic [2:0]        func3_q;
    logic              ren_q, wen_q, reg_wen_q, misalign_q;
    logic [4:0]        rd_q;
    logic [1:0]        wsel_q;

    logic              accept, mem_in, misalign_in, ms_ready_go;
    logic [XLEN-1:0]   al_wdata, al_ldata;
    logic [NB-1:0]     al_wstrb;

    assign mem_in = es_mem_ren | es_mem_wen;
`ifdef YSYX_22040759_MISALIGN_CHK_EN
    assign misalign_in = mem_in && is_misaligned(es_alu_result[2:0], es_func3[1:0]);
    assign ms_misalign = ms_valid_q && misalign_q;
`else
    assign misalign_in = 1'b0;
`endif

    // Handshake: a mem op is ready only in DONE; a non-mem op is ready as soon as it is held
    always_comb begin
        ms_ready_go    = (state_q == StDone) || (ms_valid_q && !(ren_q || wen_q));
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
        accept         = es_to_ms_valid && ms_allowin;
        ms_valid_d     = ms_allowin ? es_to_ms_valid : ms_valid_q;
    end

    // Access sequencing; misaligned ops (when checked) skip the bus and go straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept && mem_in) state_d = misalign_in ? StDone : StReq;
            StReq:  if (dmem_gnt) state_d = wen_q ? StDone : StWait;
            StWait: if (dmem_rvalid) state_d = StDone;
            StDone: begin
                if (ms_to_ws_valid && ws_allowin) begin
                    if (accept && mem_in) state_d = misalign_in ? StDone : StReq;
                    else                  state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and pipeline registers; payload only changes on accept so it holds under stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ms_valid_q <= 1'b0;
            pc_q       <= '0;
            alu_q      <= '0;
            src2_q     <= '0;
            rdata_q    <= '0;
            inst_q     <= NOP_INST;
            func3_q    <= '0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            reg_wen_q  <= 1'b0;
            misalign_q <= 1'b0;
            rd_q       <= '0;
            wsel_q     <= '0;
        end else begin
            state_q    <= state_d;
            ms_valid_q <= ms_valid_d;
            if (accept) begin
                pc_q       <= es_pc;
                alu_q      <= es_alu_result;
                src2_q     <= es_src2;
                rdata_q    <= '0;
                inst_q     <= es_inst;
                func3_q    <= es_func3;
                ren_q      <= es_mem_ren;
                wen_q      <= es_mem_wen;
                reg_wen_q  <= es_reg_wen;
                misalign_q <= misalign_in;
                rd_q       <= es_rd;
                wsel_q     <= es_wreg_sel;
            end else if (state_q == StWait && dmem_rvalid) begin
                rdata_q <= dmem_rdata;
            end
        end
    end

    ysyx_22040759_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .func3_i   (func3_q),
        .off_i     (alu_q[OFFW-1:0]),
        .st_data_i (src2_q),
        .ld_raw_i  (rdata_q),
        .wdata_o   (al_wdata),
        .wstrb_o   (al_wstrb),
        .ld_data_o (al_ldata)
    );

    // Bus and WB-facing outputs, all derived from registered state
    always_comb begin
        dmem_req      = (state_q == StReq);
        dmem_we       = dmem_req && wen_q;
        dmem_addr     = alu_q[ADDR_W-1:0] & ALIGN_MASK;
        dmem_wdata    = al_wdata;
        dmem_wstrb    = dmem_we ? al_wstrb : '0;
        ms_pc         = pc_q;
        ms_alu_result = alu_q;
        ms_rdata      = ms_valid_q ? al_ldata : '0;
        ms_inst       = ms_valid_q ? inst_q : NOP_INST;
        ms_reg_wen    = ms_valid_q && reg_wen_q && !misalign_q;
        ms_rd         = rd_q;
        ms_wreg_sel   = wsel_q;
    end

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Scoreboard bench for the memory stage: stimulus pushes expectations, monitor pops on handoff/grant.
module tb_ysyx_22040759_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        es_to_ms_valid = 1'b0;
    logic        ms_allowin;
    logic [63:0] es_pc = '0, es_alu_result = '0, es_src2 = '0;
    logic [31:0] es_inst = '0;
    logic [2:0]  es_func3 = '0;
    logic        es_mem_ren = 1'b0, es_mem_wen = 1'b0, es_reg_wen = 1'b0;
    logic [4:0]  es_rd = '0;
    logic [1:0]  es_wreg_sel = '0;
    logic        ws_allowin = 1'b1;
    logic        ms_to_ws_valid;
    logic [63:0] ms_pc, ms_alu_result, ms_rdata;
    logic [31:0] ms_inst;
    logic        ms_reg_wen;
    logic [4:0]  ms_rd;
    logic [1:0]  ms_wreg_sel;
`ifdef YSYX_22040759_MISALIGN_CHK_EN
    logic        ms_misalign;
`endif
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = '0;

    always #5 clk = ~clk;

    ysyx_22040759_mem_stage #(.XLEN(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_src2(es_src2), .es_inst(es_inst),
        .es_func3(es_func3), .es_mem_ren(es_mem_ren), .es_mem_wen(es_mem_wen),
        .es_reg_wen(es_reg_wen), .es_rd(es_rd), .es_wreg_sel(es_wreg_sel),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
        .ms_alu_result(ms_alu_result), .ms_rdata(ms_rdata), .ms_inst(ms_inst),
        .ms_reg_wen(ms_reg_wen), .ms_rd(ms_rd), .ms_wreg_sel(ms_wreg_sel),
`ifdef YSYX_22040759_MISALIGN_CHK_EN
        .ms_misalign(ms_misalign),
`endif
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [1:0]  wsel;
    } out_t;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } mem_t;

    out_t out_q[$];
    mem_t mem_q[$];
    out_t oe;
    mem_t me;
    int   errors = 0;
    int   checks = 0;
    int   req_cnt = 0;
    int   hand_cnt = 0;

    function automatic logic [63:0] byte_mask(input logic [7:0] s);
        logic [63:0] m = '0;
        for (int i = 0; i < 8; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on WB handoff and on bus grant
    always @(negedge clk) begin
        if (rst) begin
            if (dmem_req) req_cnt++;
            if (ms_to_ws_valid && ws_allowin) begin
                hand_cnt++;
                checks++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_handoff: got pc=%h expected none", ms_pc);
                end else begin
                    oe = out_q.pop_front();
                    if (ms_pc !== oe.pc || ms_inst !== oe.inst || ms_alu_result !== oe.alu ||
                        ms_rdata !== oe.rdata || ms_reg_wen !== oe.reg_wen || ms_rd !== oe.rd ||
                        ms_wreg_sel !== oe.wsel) begin
                        errors++;
                        $display("FAIL handoff: got pc=%h inst=%h alu=%h rdata=%h wen=%b rd=%0d sel=%0d expected pc=%h inst=%h alu=%h rdata=%h wen=%b rd=%0d sel=%0d",
                                 ms_pc, ms_inst, ms_alu_result, ms_rdata, ms_reg_wen, ms_rd,
                                 ms_wreg_sel, oe.pc, oe.inst, oe.alu, oe.rdata, oe.reg_wen,
                                 oe.rd, oe.wsel);
                    end
                end
            end
            if (dmem_req && dmem_gnt) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: got addr=%h expected none", dmem_addr);
                end else begin
                    me = mem_q.pop_front();
                    if (dmem_addr !== me.addr || dmem_we !== me.we ||
                        (me.we && (dmem_wstrb !== me.wstrb ||
                         (dmem_wdata & byte_mask(me.wstrb)) !== me.wdata))) begin
                        errors++;
                        $display("FAIL dmem_access: got addr=%h we=%b strb=%h wdata=%h expected addr=%h we=%b strb=%h wdata=%h",
                                 dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
                                 me.addr, me.we, me.wstrb, me.wdata);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input logic [2:0] f3,
                         input logic ren, input logic wen, input logic rwen, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] src2);
        es_pc = pc; es_inst = inst; es_func3 = f3; es_mem_ren = ren; es_mem_wen = wen;
        es_reg_wen = rwen; es_rd = rd; es_alu_result = alu; es_src2 = src2;
        es_wreg_sel = ren ? 2'd1 : 2'd0;
        es_to_ms_valid = 1'b1;
    endtask

    // Holds valid until accepted; returns at posedge+1 of the first cycle the op is held
    task automatic issue(input logic [63:0] pc, input logic [31:0] inst, input logic [2:0] f3,
                         input logic ren, input logic wen, input logic rwen, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] src2);
        bit ok = 1'b0;
        drive(pc, inst, f3, ren, wen, rwen, rd, alu, src2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ms_allowin) begin ok = 1'b1; break; end
        end
        if (!ok) check("allowin_timeout", 64'(ms_allowin), 64'd1);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic serve(input int gnt_delay, input bit is_load, input logic [63:0] rdata);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dmem_req) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("dmem_req_timeout", 64'(dmem_req), 64'd1);
        end else begin
            for (int i = 0; i < gnt_delay; i++) begin @(posedge clk); #1; end
            dmem_gnt = 1'b1;
            @(posedge clk); #1;
            dmem_gnt = 1'b0;
            if (is_load) begin
                dmem_rvalid = 1'b1; dmem_rdata = rdata;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0; dmem_rdata = '0;
            end
        end
    endtask

    task automatic run_op(input logic [63:0] pc, input logic [31:0] inst, input logic [2:0] f3,
                          input logic ren, input logic wen, input logic rwen, input logic [4:0] rd,
                          input logic [63:0] alu, input logic [63:0] src2,
                          input logic [31:0] e_addr, input logic [7:0] e_strb,
                          input logic [63:0] e_wdata, input logic [63:0] bus_rdata,
                          input logic [63:0] e_rdata, input int gnt_delay);
        out_q.push_back('{pc, inst, alu, e_rdata, rwen, rd, ren ? 2'd1 : 2'd0});
        if (ren || wen) mem_q.push_back('{e_addr, wen, e_wdata, e_strb});
        issue(pc, inst, f3, ren, wen, rwen, rd, alu, src2);
        if (ren || wen) serve(gnt_delay, ren, bus_rdata);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, h0;
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_ms_to_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_ms_allowin", 64'(ms_allowin), 64'd1);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_dmem_we", 64'(dmem_we), 64'd0);
        check("rst_dmem_wstrb", 64'(dmem_wstrb), 64'd0);
        check("rst_ms_inst", 64'(ms_inst), 64'h13);
        check("rst_ms_reg_wen", 64'(ms_reg_wen), 64'd0);
        check("rst_ms_rdata", ms_rdata, 64'd0);
        check("rst_ms_pc", ms_pc, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Non-mem op: ready in the cycle it is held
        run_op(64'h80000000, 32'h00100093, 3'b000, 0, 0, 1, 5'd1, 64'h1234, 64'h0,
               32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0);

        // SD, grant after two cycles: req high for exactly three cycles, one handoff
        r0 = req_cnt; h0 = hand_cnt;
        run_op(64'h80000004, 32'h00b53423, 3'b011, 0, 1, 0, 5'd0, 64'h80000008,
               64'h1122334455667788, 32'h80000008, 8'hFF, 64'h1122334455667788, 64'h0, 64'h0, 2);
        check("sd_req_cycles", 64'(req_cnt - r0), 64'd3);
        check("sd_handoffs", 64'(hand_cnt - h0), 64'd1);

        // Loads with sign/zero extension from various lanes
        run_op(64'h80000008, 32'h00350083, 3'b000, 1, 0, 1, 5'd1, 64'h80000003, 64'h0,
               32'h80000000, 8'h0, 64'h0, 64'h0000000080000000, 64'hFFFFFFFFFFFFFF80, 1);
        run_op(64'h8000000C, 32'h00354103, 3'b100, 1, 0, 1, 5'd2, 64'h80000003, 64'h0,
               32'h80000000, 8'h0, 64'h0, 64'h0000000080000000, 64'h0000000000000080, 0);
        run_op(64'h80000010, 32'h00251183, 3'b001, 1, 0, 1, 5'd3, 64'h80000002, 64'h0,
               32'h80000000, 8'h0, 64'h0, 64'h000000009ABC0000, 64'hFFFFFFFFFFFF9ABC, 0);
        run_op(64'h80000014, 32'h00456203, 3'b110, 1, 0, 1, 5'd4, 64'h80000004, 64'h0,
               32'h80000000, 8'h0, 64'h0, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF, 1);

        // Stores in sub-dword lanes
        run_op(64'h80000018, 32'h00b51323, 3'b001, 0, 1, 0, 5'd0, 64'h80000006,
               64'h000000000000ABCD, 32'h80000000, 8'hC0, 64'hABCD000000000000, 64'h0, 64'h0, 0);
        run_op(64'h8000001C, 32'h00b500a3, 3'b000, 0, 1, 0, 5'd0, 64'h80000001,
               64'h77665544332211A5, 32'h80000000, 8'h02, 64'h000000000000A500, 64'h0, 64'h0, 1);
        run_op(64'h80000020, 32'h00b52623, 3'b010, 0, 1, 0, 5'd0, 64'h8000000C,
               64'h00000000CAFEBABE, 32'h80000008, 8'hF0, 64'hCAFEBABE00000000, 64'h0, 64'h0, 0);

`ifdef YSYX_22040759_MISALIGN_CHK_EN
        // Misaligned LW: no bus access, flagged and reg write suppressed
        r0 = req_cnt;
        out_q.push_back('{64'h80000024, 32'h00252083, 64'h80000002, 64'h0, 1'b0, 5'd1, 2'd1});
        issue(64'h80000024, 32'h00252083, 3'b010, 1, 0, 1, 5'd1, 64'h80000002, 64'h0);
        @(negedge clk);
        check("mis_dmem_req", 64'(dmem_req), 64'd0);
        check("mis_flag", 64'(ms_misalign), 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        check("mis_req_cycles", 64'(req_cnt - r0), 64'd0);
`endif

        // LD held in DONE by WB stall while a second load waits upstream
        ws_allowin = 1'b0;
        r0 = req_cnt;
        out_q.push_back('{64'h80000030, 32'h01053283, 64'h80000010, 64'h0123456789ABCDEF,
                          1'b1, 5'd5, 2'd1});
        mem_q.push_back('{32'h80000010, 1'b0, 64'h0, 8'h0});
        out_q.push_back('{64'h80000034, 32'h00452303, 64'h80000004, 64'hFFFFFFFFDEADBEEF,
                          1'b1, 5'd6, 2'd1});
        mem_q.push_back('{32'h80000000, 1'b0, 64'h0, 8'h0});
        issue(64'h80000030, 32'h01053283, 3'b011, 1, 0, 1, 5'd5, 64'h80000010, 64'h0);
        drive(64'h80000034, 32'h00452303, 3'b010, 1, 0, 1, 5'd6, 64'h80000004, 64'h0);
        serve(0, 1, 64'h0123456789ABCDEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(ms_to_ws_valid), 64'd1);
            check("stall_pc", ms_pc, 64'h80000030);
            check("stall_rdata", ms_rdata, 64'h0123456789ABCDEF);
            check("stall_allowin", 64'(ms_allowin), 64'd0);
            check("stall_no_req", 64'(dmem_req), 64'd0);
        end
        check("stall_req_cycles", 64'(req_cnt - r0), 64'd1);
        @(posedge clk); #1 ws_allowin = 1'b1;
        @(posedge clk); #1 es_to_ms_valid = 1'b0;
        serve(1, 1, 64'hDEADBEEF00000000);
        repeat (2) begin @(posedge clk); #1; end

        // Reset in WAIT, then stray rvalid/gnt: nothing must come out
        h0 = hand_cnt;
        mem_q.push_back('{32'h80000020, 1'b0, 64'h0, 8'h0});
        issue(64'h80000038, 32'h02053383, 3'b011, 1, 0, 1, 5'd7, 64'h80000020, 64'h0);
        dmem_gnt = 1'b1;
        @(posedge clk); #1 dmem_gnt = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rstw_inst", 64'(ms_inst), 64'h13);
        check("rstw_req", 64'(dmem_req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 64'hFFFF0000FFFF0000;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_gnt = 1'b0; dmem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(ms_to_ws_valid), 64'd0);
            check("post_rst_inst", 64'(ms_inst), 64'h13);
            check("post_rst_req", 64'(dmem_req), 64'd0);
            check("post_rst_allowin", 64'(ms_allowin), 64'd1);
        end
        check("post_rst_handoffs", 64'(hand_cnt - h0), 64'd0);
        @(posedge clk); #1;

        // Recovery after reset
        run_op(64'h80000100, 32'h05500513, 3'b000, 0, 0, 1, 5'd10, 64'h55, 64'h0,
               32'h0, 8'h0, 64'h0, 64'h0, 64'h0, 0);

        repeat (3) begin @(posedge clk); #1; end
        check("out_queue_empty", 64'(out_q.size()), 64'd0);
        check("mem_queue_empty", 64'(mem_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040759_mem_stage.md
YSYX_22040759_MEM_STAGE -- requirements
Module: ysyx_22040759_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning data-bus address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state samples on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port es_to_ms_valid  in  1  upstream instruction valid.
REQ-006 SHALL have port ms_allowin  out  1  stage can accept.
REQ-007 SHALL have port es_pc, es_alu_result, es_src2  in  XLEN each  PC, address or ALU result, store data.
REQ-008 SHALL have port es_inst  in  32; es_func3  in  3; es_mem_ren, es_mem_wen, es_reg_wen  in  1; es_rd  in  5; es_wreg_sel  in  2.
REQ-009 SHALL have port ws_allowin  in  1; ms_to_ws_valid  out  1.
REQ-010 SHALL have port ms_pc, ms_alu_result, ms_rdata  out  XLEN; ms_inst  out  32; ms_reg_wen  out  1; ms_rd  out  5; ms_wreg_sel  out  2.
REQ-011 SHALL have port dmem_req  out  1; dmem_we  out  1; dmem_addr  out  ADDR_W; dmem_wdata  out  XLEN; dmem_wstrb  out  XLEN/8; dmem_gnt  in  1; dmem_rvalid  in  1; dmem_rdata  in  XLEN.

Function
REQ-012 SHALL accept upstream when es_to_ms_valid && ms_allowin; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-013 SHALL run FSM IDLE, REQ, WAIT, DONE; IDLE->REQ on accepting a mem op; otherwise an accepted non-mem op is ready_go in the same cycle.
REQ-014 SHALL hold dmem_req=1 with stable addr/we/wdata/wstrb in REQ until dmem_gnt; store gnt -> DONE; load gnt -> WAIT.
REQ-015 SHALL, in WAIT, capture dmem_rdata on dmem_rvalid and go to DONE; rvalid outside WAIT is ignored.
REQ-016 SHALL assert ms_ready_go only in DONE or for valid non-mem ops; DONE->IDLE when ms_to_ws_valid && ws_allowin, or ->REQ directly on back-to-back mem accept in that cycle.
REQ-017 SHALL drive dmem_addr = es_alu_result[ADDR_W-1:0] aligned down to XLEN/8 bytes.
REQ-018 SHALL generate wstrb/wdata from func3[1:0] (byte/half/word/dword) and addr low bits: data shifted into lane, strobe covers exactly the access bytes.
REQ-019 SHALL extract load data by addr low bits and sign-extend for func3 000/001/010, zero-extend for 100/101/110, pass 011 unchanged (XLEN=64 only).
REQ-020 SHALL, when ms_valid=0, present ms_inst=32'h13, ms_reg_wen=0, ms_rdata=0.
REQ-021 SHALL hold all ms_* outputs stable while ms_to_ws_valid && !ws_allowin.
REQ-022 SHALL issue dmem_req for at most one access per instruction; no re-issue after gnt.

Reset
REQ-023 SHALL, on rst low, immediately clear ms_valid, FSM=IDLE, dmem_req=0, dmem_we=0, dmem_wstrb=0, ms_reg_wen=0, ms_inst=32'h13, other outputs 0.
REQ-024 SHALL, on reset mid-transaction, abandon it; a later stray rvalid/gnt SHALL have no effect.

Configuration
REQ-025 SHALL, with YSYX_22040759_MISALIGN_CHK_EN defined, flag accesses whose address is not size-aligned: no dmem_req, go to DONE, output ms_misalign=1 (extra 1-bit port), ms_reg_wen forced 0.
REQ-026 SHALL, without the macro, omit ms_misalign and perform misaligned accesses within the lane as computed (no check).

Structure
REQ-027 SHALL take FSM state encoding, func3 load/store codes and NOP constant 32'h13 from shared package ysyx_22040759_pkg.
REQ-028 SHALL place lane alignment (wstrb/wdata shift, load extract/extend) in sub-module ysyx_22040759_lsu_align; FSM and pipeline registers stay in top.

Verification
REQ-029 SHALL cover: SD addr 0x80000008 data 0x1122334455667788, gnt after 2 cycles -> dmem_req 3 cycles, wstrb 0xFF, DONE, one ms_to_ws_valid.
REQ-030 SHALL cover: LB addr 0x80000003, rdata 0x00000000_80000000 -> ms_rdata 0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
REQ-031 SHALL cover: SH addr 0x80000006 data 0xABCD -> wstrb 0xC0, wdata[63:48]=0xABCD.
REQ-032 SHALL cover: load in DONE with ws_allowin=0 for 4 cycles -> outputs stable, ms_allowin=0, no new dmem_req.
REQ-033 SHALL cover: rst low during WAIT, rvalid next cycle -> ms_to_ws_valid stays 0, ms_inst=32'h13.
REQ-034 SHALL cover: with macro, LW addr 0x80000002 -> no dmem_req, ms_misalign=1 in next cycle.
